// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock divider and its users.
//   DIV_MIN          smallest accepted period (a period of 1 or 0 has no low phase)
//   DIV_1KHZ_AT_50M  50 MHz -> 1 kHz (display scan timebase)
//   DIV_2HZ_AT_1K    1 kHz  -> 2 Hz  (blink)
//   DIV_1HZ_AT_1K    1 kHz  -> 1 Hz  (seconds)
//   CNT_W_DEFAULT    default counter / divisor width
package clk_div_pkg;

    localparam int unsigned CNT_W_DEFAULT   = 32;
    localparam int unsigned DIV_MIN         = 2;
    localparam int unsigned DIV_1KHZ_AT_50M = 50000;
    localparam int unsigned DIV_2HZ_AT_1K   = 500;
    localparam int unsigned DIV_1HZ_AT_1K   = 1000;

endpackage

// File: rtl/clk_div_prog.sv
// Runtime-programmable, glitch-free clock divider / tick generator.
// Divides clk_50Mhz by a period N (div_act). A new divisor is held in a
// shadow register and only applied at a period boundary (wrap or clr),
// so clk_out never produces a runt pulse.
//
// Ports:
//   clk_50Mhz  in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   count enable; 0 freezes counter and clk_out
//   clr        in   synchronous restart of the current period (beats en)
//   div_load   in   one-cycle strobe, capture div_val
//   div_val    in   requested period N (must be >= DIV_MIN)
//   clk_out    out  low floor(N/2) cycles, high ceil(N/2) cycles
//   tick       out  one-cycle pulse while cnt==0 following a wrap
//   div_err    out  one-cycle pulse when a load is rejected
//   div_act    out  period currently in effect
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned DIV_DEFAULT = DIV_1KHZ_AT_50M
) (
    input  logic             clk_50Mhz,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    output logic             clk_out,
    output logic             tick,
    output logic             div_err,
    output logic [CNT_W-1:0] div_act
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] DIV_LO  = CNT_W'(DIV_MIN);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] pending;
    logic [CNT_W-1:0] pending_nxt;
    logic [CNT_W-1:0] div_act_nxt;
    logic             pending_vld;
    logic             pending_vld_nxt;
    logic             clk_out_nxt;
    logic             tick_nxt;
    logic             div_err_nxt;
    logic             wrap;
    logic             boundary;
    logic             load_ok;

    always_comb begin
        wrap     = en && (cnt == (div_act - ONE));
        boundary = wrap || clr;
        load_ok  = div_load && (div_val >= DIV_LO);

        div_err_nxt     = div_load && (div_val < DIV_LO);
        pending_nxt     = pending;
        pending_vld_nxt = pending_vld;
        div_act_nxt     = div_act;

        // At a boundary a load arriving in the same cycle wins over the
        // shadow value; otherwise a valid load just refreshes the shadow.
        if (boundary) begin
            if (load_ok) begin
                div_act_nxt = div_val;
            end else if (pending_vld) begin
                div_act_nxt = pending;
            end
            pending_vld_nxt = 1'b0;
        end else if (load_ok) begin
            pending_nxt     = div_val;
            pending_vld_nxt = 1'b1;
        end

        if (clr) begin
            cnt_nxt = '0;
        end else if (wrap) begin
            cnt_nxt = '0;
        end else if (en) begin
            cnt_nxt = cnt + ONE;
        end else begin
            cnt_nxt = cnt;
        end

        // Square output compares against the divisor that will be in effect
        // after this edge, so it is always low in the cnt==0 cycle.
        if (clr) begin
            clk_out_nxt = 1'b0;
        end else if (en) begin
            clk_out_nxt = (cnt_nxt >= (div_act_nxt >> 1));
        end else begin
            clk_out_nxt = clk_out;
        end

        tick_nxt = wrap && !clr;
    end

    always_ff @(posedge clk_50Mhz or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
            div_err     <= 1'b0;
            div_act     <= DIV_RST;
            pending     <= '0;
            pending_vld <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            clk_out     <= clk_out_nxt;
            tick        <= tick_nxt;
            div_err     <= div_err_nxt;
            div_act     <= div_act_nxt;
            pending     <= pending_nxt;
            pending_vld <= pending_vld_nxt;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios followed by
// randomized enable/clear/load traffic, compared every cycle against a
// behavioural model of the divider (phase within period, period, queue of
// requested periods).
module tb_clk_div_prog;

    localparam int unsigned W = 16;

    logic         clk_50Mhz = 1'b0;
    logic         rst_n;
    logic         en;
    logic         clr;
    logic         div_load;
    logic [W-1:0] div_val;
    logic         clk_out;
    logic         tick;
    logic         div_err;
    logic [W-1:0] div_act;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state
    int unsigned m_phase;
    int unsigned m_period;
    int unsigned m_pend[$];
    bit          m_clk;
    bit          m_tick;
    bit          m_err;

    clk_div_prog #(
        .CNT_W      (W),
        .DIV_DEFAULT(4)
    ) dut (
        .clk_50Mhz(clk_50Mhz),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .div_load (div_load),
        .div_val  (div_val),
        .clk_out  (clk_out),
        .tick     (tick),
        .div_err  (div_err),
        .div_act  (div_act)
    );

    always #5 clk_50Mhz = ~clk_50Mhz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_period = 4;
        m_pend.delete();
        m_clk    = 1'b0;
        m_tick   = 1'b0;
        m_err    = 1'b0;
    endtask

    // One rising edge of the model, using the inputs as they stood at the edge.
    task automatic model_edge();
        bit          end_of_period;
        bit          ok;
        int unsigned v;
        v             = int'(div_val);
        ok            = div_load && v >= 2;
        m_err         = div_load && v < 2;
        end_of_period = en && (m_phase + 1 == m_period);
        m_tick        = end_of_period && !clr;
        if (clr)
            m_phase = 0;
        else if (en)
            m_phase = (m_phase + 1) % m_period;
        if (clr || end_of_period) begin
            if (ok)
                m_period = v;
            else if (m_pend.size() > 0)
                m_period = m_pend[$];
            m_pend.delete();
        end else if (ok) begin
            m_pend.push_back(v);
        end
        // Low for the first floor(N/2) positions of each period
        if (clr)
            m_clk = 1'b0;
        else if (en)
            m_clk = (m_phase >= m_period / 2);
    endtask

    task automatic cycle();
        @(posedge clk_50Mhz);
        model_edge();
        #1;
        check("clk_out", 32'(clk_out), 32'(m_clk));
        check("tick",    32'(tick),    32'(m_tick));
        check("div_err", 32'(div_err), 32'(m_err));
        check("div_act", 32'(div_act), m_period);
        clr      = 1'b0;
        div_load = 1'b0;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_phase(input int unsigned p);
        int unsigned k;
        k = 0;
        while (m_phase != p && k < 64) begin
            cycle();
            k++;
        end
        check("wait_phase_timeout", 32'(m_phase == p), 32'd1);
    endtask

    task automatic load(input int unsigned v);
        div_load = 1'b1;
        div_val  = W'(v);
        cycle();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_clk_out"}, 32'(clk_out), 32'd0);
        check({tag, "_tick"},    32'(tick),    32'd0);
        check({tag, "_div_err"}, 32'(div_err), 32'd0);
        check({tag, "_div_act"}, 32'(div_act), 32'd4);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        clr      = 1'b0;
        div_load = 1'b0;
        div_val  = '0;
        model_reset();
        #12;
        check_reset_vals("reset");
        @(posedge clk_50Mhz);
        #1;
        rst_n = 1'b1;
        en    = 1'b1;

        // N=4 out of reset: 0,0,1,1 with first tick after 4 edges
        run(12);

        // Load 5 mid-period: takes effect at the next wrap
        wait_phase(1);
        load(5);
        run(14);

        // Reload 4, then rejected loads of 1 and 0
        load(4);
        run(6);
        load(1);
        run(3);
        load(0);
        run(6);

        // Freeze at phase 2 for three cycles
        wait_phase(2);
        en = 1'b0;
        run(3);
        en = 1'b1;
        run(6);

        // Pending 6 applied by clr at phase 2
        wait_phase(0);
        load(6);
        wait_phase(2);
        clr = 1'b1;
        cycle();
        check("clr_div_act", 32'(div_act), 32'd6);
        run(14);

        // Async reset mid-period with pending 7: pending value discarded
        wait_phase(1);
        load(7);
        cycle();
        rst_n = 1'b0;
        #2;
        check_reset_vals("async_reset");
        model_reset();
        @(posedge clk_50Mhz);
        #1;
        check_reset_vals("held_reset");
        rst_n = 1'b1;
        run(12);

        // Load on the wrap cycle bypasses the shadow
        wait_phase(3);
        load(3);
        run(8);

        // Randomized traffic
        for (int unsigned i = 0; i < 500; i++) begin
            en       = ($urandom_range(0, 7) != 0);
            clr      = ($urandom_range(0, 29) == 0);
            div_load = ($urandom_range(0, 9) == 0);
            div_val  = W'($urandom_range(0, 9));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Runtime-programmable, glitch-free clock divider / tick generator for the watch timebase. It divides clk_50Mhz by a period N (input cycles per output period) and produces two outputs: a near-50% square wave and a one-cycle tick enable. The divisor can be reloaded at run time and takes effect only at a period boundary, so the output never produces a runt pulse. It replaces fixed dividers feeding display scan (1 kHz), seconds (1 Hz) and blink (2 Hz) logic; several instances may be cascaded via tick→en.

Parameters:
CNT_W, 32, width of counter and divisor.
DIV_DEFAULT, 50000, period N after reset (1 kHz from 50 MHz); must be >= 2.

Ports:
clk_50Mhz  input  1  system clock, all logic on rising edge.
rst_n  input  1  asynchronous, active-low reset.
en  input  1  count enable; 0 freezes the divider.
clr  input  1  synchronous restart of the current period.
div_load  input  1  one-cycle strobe; capture div_val.
div_val  input  CNT_W  requested period N.
clk_out  output  1  square output; low floor(N/2) cycles, high ceil(N/2) cycles.
tick  output  1  one-cycle pulse per period.
div_err  output  1  one-cycle pulse when a load is rejected.
div_act  output  CNT_W  period currently in effect.

Behaviour:
- Reset (async, rst_n=0): cnt=0, clk_out=0, tick=0, div_err=0, div_act=DIV_DEFAULT, pending_vld=0.
- Counter: cnt runs 0..N-1 with N=div_act. When en=1: cnt_next = (cnt==N-1) ? 0 : cnt+1. "wrap" = en & (cnt==N-1).
- All outputs are registered and updated in the same edge as cnt.
- clk_out = (cnt_next >= N_next/2), where N_next is the divisor in effect after this edge. Consequences: clk_out is 0 while cnt=0, so it is consistent with reset, and clk_out falls at every wrap.
- tick <= wrap. tick is high for exactly one cycle while cnt==0 after a wrap, and is never high out of reset.
- en=0: cnt and clk_out hold, tick=0. Loads are still accepted into the shadow register.
- clr=1: cnt<=0, clk_out<=0, tick<=0. clr has priority over en. Any pending divisor is applied in the same edge.
- Load rules:
  - div_load with div_val>=2: pending<=div_val, pending_vld<=1. A later load before application overwrites the earlier one (last wins).
  - div_load with div_val<2: div_err<=1 for one cycle; pending and div_act are unchanged.
- Application: when wrap=1 or clr=1 and pending_vld=1, div_act<=pending and pending_vld<=0.
- div_load in the same cycle as a wrap or clr: div_val (if valid) bypasses the shadow and becomes div_act at that edge.
- Odd N, e.g. N=5: 2 cycles low, 3 high. N=2: alternate 0/1 with a tick every 2 cycles.
- Arithmetic: unsigned CNT_W throughout; N/2 is a right shift. cnt never exceeds div_act-1 because the divisor changes only when cnt becomes 0.
- Reset mid-operation: immediate return to reset values; a pending load is discarded.

Decomposition:
- Package clk_div_pkg holds:
  - DIV_MIN=2
  - DIV_1KHZ_AT_50M=50000
  - DIV_2HZ_AT_1K=500
  - DIV_1HZ_AT_1K=1000
  - CNT_W default 32
- No sub-module. The shadow/load logic and the counter stay in one module. Cascades are built at top level by chaining tick into the next instance's en.

Test Plan:
- Reset release with DIV_DEFAULT=4, en=1 -> clk_out sequence 0,0,1,1 repeating; tick high on each cnt=0 cycle after a wrap, first at cycle 4; div_act=4.
- Load 5 at cnt=1 with N=4 -> current period completes at 4 cycles; next periods 2 low / 3 high; tick spacing 4 then 5; div_act changes exactly at the wrap.
- Load 1 -> div_err pulses one cycle; div_act stays 4; waveform unchanged. Load 0 -> same result.
- en low for 3 cycles at cnt=2 -> cnt, clk_out frozen, tick=0; resume continues from cnt=3 with no extra tick.
- clr at cnt=2 with pending 6 -> next cycle cnt=0, clk_out=0, div_act=6, tick=0; next tick 6 cycles later.
- rst_n pulsed low mid-period with pending 7 -> outputs at reset values immediately; after release div_act=4 and the pending value is lost.
